mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single-port data RAM between two requesters: the CPU load/store path (CU RAM_in/RAM_out sequencing) and the UART program/debug loader.
- Serialises accesses, handles the RAM read latency and returns per-requester acks and read data.
- Drives cpu_busy into the CU busyFlag input, which freezes the step counter while a CPU access is pending.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
RAM_LAT, 1, cycles from ram_en (read) to valid ram_rdata; legal range 1..15

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
boot_mode  in  1  1 = loader has exclusive access; CPU requests are not granted
cpu_req  in  1  CPU request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack, held until next CPU read completes
cpu_busy  out  1  to CU busyFlag: cpu_req high and CPU access not completing this cycle
ldr_req  in  1  loader request, level, held until ldr_ack
ldr_we  in  1  loader write enable
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_ack  out  1  one-cycle completion pulse to loader
ldr_rdata  out  DATA_W  loader read data, same rules as cpu_rdata
ram_en  out  1  RAM access strobe, one cycle per transaction
ram_we  out  1  RAM write enable, qualified by ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
owner  out  1  0 = CPU, 1 = loader; owner of the current or last transaction

Behaviour:
- Reset (sync, active-high): state = IDLE; cpu_ack, ldr_ack, ram_en, ram_we = 0; ram_addr, ram_wdata, cpu_rdata, ldr_rdata = 0; owner = 1; last_grant = loader, so the CPU wins the first tie. Reset mid-transaction abandons it: no ack is issued and ram_en drops on the next cycle.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Eligible requests are ldr_req, and cpu_req only when boot_mode = 0.
  - None eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the requester other than last_grant (round-robin).
  - On grant, latch we/addr/wdata of the winner into ram_we/ram_addr/ram_wdata, set owner, go to ACCESS.
- ACCESS: ram_en = 1 for exactly this cycle.
  - Write: go to DONE.
  - Read with RAM_LAT = 1: go to DONE.
  - Read with RAM_LAT > 1: load a down-counter with RAM_LAT-2, go to WAIT.
- WAIT: decrement the counter; at 0 go to DONE. The counter is 4 bits and never wraps below 0.
- Read data capture: on the edge entering DONE, ram_rdata is registered into the owner's rdata. The other requester's rdata is unchanged.
- DONE: the owner's ack = 1 for this cycle only. last_grant <= owner. Next state is IDLE.
- Latency, with req sampled in IDLE at cycle T:
  - Write: ram_en at T+1, ack at T+2.
  - Read: ram_en at T+1, ack at T+1+RAM_LAT.
  - Minimum spacing between back-to-back grants is 3 cycles (IDLE, ACCESS, DONE).
- Requester rule: req must be low by the clock edge that ends its ack cycle. A req still high in the following IDLE is treated as a new request.
- cpu_busy = cpu_req AND NOT (state == DONE AND owner == 0). It is combinational, so the CU resumes in the ack cycle.
  - With boot_mode = 1 and cpu_req = 1, cpu_busy stays 1 indefinitely.
- boot_mode changes only affect IDLE decisions. An in-flight CPU transaction completes normally.
- ram_addr, ram_wdata and ram_we hold their values outside ACCESS. ram_we has no effect while ram_en = 0.
- Starvation bound: with both requesters continuously requesting and boot_mode = 0, grants alternate strictly CPU, loader, CPU, and so on.

Test Plan:
1. Reset, then CPU write addr 0x10 data 0xA5 with RAM_LAT=1 -> ram_en=1, ram_we=1 at T+1; cpu_ack at T+2; cpu_busy high T..T+1, low at T+2.
2. RAM_LAT=3, loader read addr 0x10 (RAM holds 0xA5) -> ram_en at T+1, ldr_ack at T+4, ldr_rdata=0xA5; cpu_rdata unchanged (0x00).
3. Both requesters hold req from T, each re-requesting after ack -> grant order CPU, loader, CPU, loader; acks 3 cycles apart; owner toggles.
4. boot_mode=1 with cpu_req and ldr_req high -> only loader is served; cpu_busy stays 1. Drop boot_mode -> CPU granted at the next IDLE.
5. Assert reset during WAIT of a loader read -> no ldr_ack; all outputs at reset values next cycle. A new CPU read after reset is served normally.
6. CPU read of 0x3C followed by loader write of 0x3C with 0x5A, then CPU read again -> cpu_rdata is the old value, then 0x5A.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port data RAM between the CPU load/store path and the
// UART program/debug loader. One transaction is in flight at a time:
// IDLE -> ACCESS (ram_en strobe) -> [WAIT while read data is in flight]
// -> DONE (ack to the owner) -> IDLE.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   boot_mode         1 = loader only, CPU requests are held off
//   cpu_req/we/addr/wdata   CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata      CPU completion pulse and read data
//   cpu_busy          to the CU busyFlag; high while a CPU access is pending
//   ldr_req/we/addr/wdata   loader request (level, held until ldr_ack)
//   ldr_ack, ldr_rdata      loader completion pulse and read data
//   ram_en/we/addr/wdata    RAM strobe and request fields
//   ram_rdata         RAM read data, valid RAM_LAT cycles after ram_en
//   owner             0 = CPU, 1 = loader; owner of current/last transaction
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boot_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_busy,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    // WAIT counts down from RAM_LAT-2 so that DONE is entered on the edge
    // where the RAM read data is valid.
    localparam logic [3:0] LP_WAIT_INIT = (RAM_LAT > 1) ? 4'(RAM_LAT - 2) : 4'd0;
    localparam bit         LP_NO_WAIT   = (RAM_LAT <= 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;

    logic              w_cpu_elig;
    logic              w_ldr_elig;
    logic              w_grant;
    logic              w_grant_ldr;
    logic              w_capture;

    assign w_cpu_elig = cpu_req & ~boot_mode;
    assign w_ldr_elig = ldr_req;

    // Loader wins when it is the only eligible requester, or when both are
    // eligible and the CPU held the last grant (round-robin).
    assign w_grant_ldr = w_ldr_elig & (~w_cpu_elig | ~r_last_grant);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cpu_elig || w_ldr_elig) begin
                    w_grant      = 1'b1;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (r_ram_we || LP_NO_WAIT) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next   = LP_WAIT_INIT;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Read data is sampled on the edge that enters DONE; writes leave the
    // requesters' read data untouched.
    assign w_capture = (w_state_next == DONE) && (r_state != DONE) && !r_ram_we;

    // Request latch, ownership and read-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= 1'b1;
            r_last_grant <= 1'b1;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_ldr_rdata  <= '0;
        end else begin
            if (w_grant) begin
                r_owner     <= w_grant_ldr;
                r_ram_we    <= w_grant_ldr ? ldr_we    : cpu_we;
                r_ram_addr  <= w_grant_ldr ? ldr_addr  : cpu_addr;
                r_ram_wdata <= w_grant_ldr ? ldr_wdata : cpu_wdata;
            end
            if (w_capture) begin
                if (r_owner) begin
                    r_ldr_rdata <= ram_rdata;
                end else begin
                    r_cpu_rdata <= ram_rdata;
                end
            end
            if (r_state == DONE) begin
                r_last_grant <= r_owner;
            end
        end
    end

    assign ram_en    = (r_state == ACCESS);
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign owner     = r_owner;
    assign cpu_ack   = (r_state == DONE) & ~r_owner;
    assign ldr_ack   = (r_state == DONE) &  r_owner;
    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;

    // Combinational so the CU step counter resumes in the ack cycle itself.
    assign cpu_busy  = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiter instances: u_dut (RAM_LAT=3, both requesters exercised) and
// u_dut1 (RAM_LAT=1, CPU port only). Each has a behavioural RAM whose read
// data is valid RAM_LAT cycles after ram_en. Stimulus pushes the expected
// ack (unit, requester, cycle, both rdata values) into a queue; a negedge
// monitor pops and compares whenever any ack appears.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    logic       clk;
    logic       reset;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    // ---- unit 0 (RAM_LAT=3) ----
    logic       boot_mode;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_ack, cpu_busy;
    logic [7:0] cpu_rdata;
    logic       ldr_req, ldr_we;
    logic [7:0] ldr_addr, ldr_wdata;
    logic       ldr_ack;
    logic [7:0] ldr_rdata;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       owner;

    // ---- unit 1 (RAM_LAT=1) ----
    logic       b1_mode;
    logic       c1_req, c1_we;
    logic [7:0] c1_addr, c1_wdata;
    logic       c1_ack, c1_busy;
    logic [7:0] c1_rdata;
    logic       l1_req, l1_we;
    logic [7:0] l1_addr, l1_wdata;
    logic       l1_ack;
    logic [7:0] l1_rdata;
    logic       en1, we1;
    logic [7:0] addr1, wdata1, rdata1;
    logic       owner1;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(LAT0)) u_dut (
        .clk(clk), .reset(reset), .boot_mode(boot_mode),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .owner(owner)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(LAT1)) u_dut1 (
        .clk(clk), .reset(reset), .boot_mode(b1_mode),
        .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
        .cpu_ack(c1_ack), .cpu_rdata(c1_rdata), .cpu_busy(c1_busy),
        .ldr_req(l1_req), .ldr_we(l1_we), .ldr_addr(l1_addr), .ldr_wdata(l1_wdata),
        .ldr_ack(l1_ack), .ldr_rdata(l1_rdata),
        .ram_en(en1), .ram_we(we1), .ram_addr(addr1), .ram_wdata(wdata1),
        .ram_rdata(rdata1), .owner(owner1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- RAM models: read data valid RAM_LAT cycles after the ram_en cycle ----
    logic [7:0] mem0 [256];
    logic [7:0] rv0;
    int         age0 = 0;
    always @(posedge clk) begin
        if (ram_en && ram_we) mem0[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) begin
            rv0  <= mem0[ram_addr];
            age0 <= 1;
        end else if (age0 != 0 && age0 < 20) begin
            age0 <= age0 + 1;
        end
    end
    assign ram_rdata = (age0 == LAT0 - 1) ? rv0 : 8'hEE;

    logic [7:0] mem1 [256];
    always @(posedge clk) begin
        if (en1 && we1) mem1[addr1] <= wdata1;
    end
    assign rdata1 = (en1 && !we1) ? mem1[addr1] : 8'hEE;

    // ---- scoreboard ----
    typedef struct {
        int         unit;
        bit         who;
        int         cyc;
        logic [7:0] crd;
        logic [7:0] lrd;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] exp_crd = 8'h00;
    logic [7:0] exp_lrd = 8'h00;
    logic [7:0] exp1_crd = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
        end
    endtask

    task automatic mon(input int unit, input bit who, input logic [7:0] crd, input logic [7:0] lrd);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ack unit=%0d who=%0d cyc=%0d", unit, who, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.unit != unit || e.who != who || e.cyc != cyc || e.crd !== crd || e.lrd !== lrd) begin
                bad++;
                $display("FAIL ack got unit=%0d who=%0d cyc=%0d crd=%0h lrd=%0h want unit=%0d who=%0d cyc=%0d crd=%0h lrd=%0h",
                         unit, who, cyc, crd, lrd, e.unit, e.who, e.cyc, e.crd, e.lrd);
            end else begin
                $display("ack unit=%0d who=%0d cyc=%0d crd=%0h lrd=%0h ok", unit, who, cyc, crd, lrd);
            end
        end
    endtask

    always @(negedge clk) begin
        if (cpu_ack) mon(0, 1'b0, cpu_rdata, ldr_rdata);
        if (ldr_ack) mon(0, 1'b1, cpu_rdata, ldr_rdata);
        if (c1_ack)  mon(1, 1'b0, c1_rdata, l1_rdata);
        if (l1_ack)  mon(1, 1'b1, c1_rdata, l1_rdata);
    end

    task automatic drop_req(input int unit, input bit who);
        if (unit == 1) c1_req = 1'b0;
        else if (who) ldr_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    // One transaction: raise req at cycle T, expect ram_en at T+1 and the ack
    // at T+2 (write) or T+1+RAM_LAT (read); drop req in the ack cycle.
    task automatic do_op(input int unit, input bit who, input bit we,
                         input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rd, input bit clr_boot);
        int   ack_k;
        bit   got;
        exp_t e;
        logic s_en, s_we, s_ack, s_busy;
        logic [7:0] s_addr, s_wdata;
        @(posedge clk); #1;
        if (clr_boot) boot_mode = 1'b0;
        if (unit == 1) begin
            c1_req = 1'b1; c1_we = we; c1_addr = addr; c1_wdata = wdata;
        end else if (who) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        ack_k = we ? 2 : 1 + ((unit == 1) ? LAT1 : LAT0);
        if (!we) begin
            if (unit == 1) exp1_crd = rd;
            else if (who) exp_lrd = rd;
            else exp_crd = rd;
        end
        e.unit = unit; e.who = who; e.cyc = cyc + ack_k;
        e.crd  = (unit == 1) ? exp1_crd : exp_crd;
        e.lrd  = (unit == 1) ? 8'h00 : exp_lrd;
        sbq.push_back(e);
        got = 1'b0;
        for (int k = 0; k < ack_k + 6 && !got; k++) begin
            @(negedge clk);
            s_en    = (unit == 1) ? en1    : ram_en;
            s_we    = (unit == 1) ? we1    : ram_we;
            s_addr  = (unit == 1) ? addr1  : ram_addr;
            s_wdata = (unit == 1) ? wdata1 : ram_wdata;
            s_busy  = (unit == 1) ? c1_busy : cpu_busy;
            s_ack   = (unit == 1) ? c1_ack : (who ? ldr_ack : cpu_ack);
            if (k == 1) begin
                chk("ram_en_access", 32'(s_en), 32'd1);
                chk("ram_we_access", 32'(s_we), 32'(we));
                chk("ram_addr", 32'(s_addr), 32'(addr));
                if (we) chk("ram_wdata", 32'(s_wdata), 32'(wdata));
            end else if (k >= 2) begin
                chk("ram_en_single", 32'(s_en), 32'd0);
            end
            if (!who) chk("cpu_busy", 32'(s_busy), (k < ack_k) ? 32'd1 : 32'd0);
            if (s_ack) begin
                got = 1'b1;
                drop_req(unit, who);
            end
        end
        if (!got) begin
            chk("ack_timeout", 32'd0, 32'd1);
            drop_req(unit, who);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b1; boot_mode = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 8'h00; ldr_wdata = 8'h00;
        b1_mode = 1'b0;
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = 8'h00; c1_wdata = 8'h00;
        l1_req = 1'b0; l1_we = 1'b0; l1_addr = 8'h00; l1_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_acks", 32'({cpu_ack, ldr_ack}), 32'd0);
        chk("rst_rdata", 32'({cpu_rdata, ldr_rdata}), 32'd0);
        chk("rst_ram_addr", 32'({ram_we, ram_addr, ram_wdata}), 32'd0);
        chk("rst1_owner", 32'(owner1), 32'd1);

        // 1: CPU write 0x10 <- 0xA5
        do_op(0, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0);
        // 2: loader read 0x10, CPU rdata stays 0
        do_op(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);

        // 3: both requesting continuously -> C, L, C, L, acks 3 cycles apart
        @(posedge clk); #1;
        t = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'hC1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h60; ldr_wdata = 8'hD2;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.unit = 0; e.who = i[0]; e.cyc = t + 2 + 3 * i;
            e.crd = exp_crd; e.lrd = exp_lrd;
            sbq.push_back(e);
        end
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 2 || k == 8)  chk("rr_owner_cpu", 32'(owner), 32'd0);
            if (k == 5 || k == 11) chk("rr_owner_ldr", 32'(owner), 32'd1);
        end
        cpu_req = 1'b0; ldr_req = 1'b0;

        // 4: boot_mode holds off the CPU; loader alone is served
        @(posedge clk); #1;
        boot_mode = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
        do_op(0, 1'b1, 1'b1, 8'h40, 8'h77, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("boot_busy", 32'(cpu_busy), 32'd1);
        end
        do_op(0, 1'b0, 1'b0, 8'h40, 8'h00, 8'h77, 1'b1);

        // 5: reset during WAIT of a loader read
        @(posedge clk); #1;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; ldr_req = 1'b0;
        exp_crd = 8'h00; exp_lrd = 8'h00; exp1_crd = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd1);
        chk("mid_rst_rdata", 32'({cpu_rdata, ldr_rdata}), 32'd0);
        chk("mid_rst_ram", 32'({ram_we, ram_addr, ram_wdata}), 32'd0);
        repeat (4) @(negedge clk);
        chk("mid_rst_no_ack", 32'(sbq.size()), 32'd0);
        do_op(0, 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);

        // 6: read / loader overwrite / read again
        do_op(0, 1'b1, 1'b1, 8'h3C, 8'h11, 8'h00, 1'b0);
        do_op(0, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h11, 1'b0);
        do_op(0, 1'b1, 1'b1, 8'h3C, 8'h5A, 8'h00, 1'b0);
        do_op(0, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h5A, 1'b0);

        // RAM_LAT=1 instance: write then read, read ack at T+2
        do_op(1, 1'b0, 1'b1, 8'h22, 8'h3D, 8'h00, 1'b0);
        do_op(1, 1'b0, 1'b0, 8'h22, 8'h00, 8'h3D, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
